// File: rtl/pipe_pkg.sv
// Shared types and default widths for the pipeline stage registers.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FULL    = 2'd1,
    SKIDDED = 2'd2
  } pipe_state_e;

  localparam int DEF_RD_W   = 5;
  localparam int DEF_DATA_W = 64;

endpackage

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, optional 2-entry skid, flush and stall counter.
// Latency 1 cycle; with SKID=1 backpressure is absorbed by the skid slot and in_ready is a flop.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int RD_W   = DEF_RD_W,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [RD_W-1:0]   in_rd,
  input  logic              in_wb,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [RD_W-1:0]   out_rd,
  output logic              out_wb,
  output logic              fwd_en,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [RD_W-1:0]   rd;
    logic              wb;
  } beat_t;

  pipe_state_e      state_q, state_d;
  beat_t            main_q, skid_q, in_beat;
  logic             main_ld, main_from_skid, skid_ld;
  logic             in_ready_q;
  logic [CNT_W-1:0] stall_q;

  assign in_beat = '{data: in_data, rd: in_rd, wb: in_wb};

  generate
    if (SKID != 0) begin : g_skid
      assign in_ready = in_ready_q;
    end else begin : g_noskid
      assign in_ready = (state_q == EMPTY) | out_ready;
    end
  endgenerate

  always_comb begin
    state_d        = state_q;
    main_ld        = 1'b0;
    main_from_skid = 1'b0;
    skid_ld        = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_valid) begin
            state_d = FULL;
            main_ld = 1'b1;
          end
        end
        FULL: begin
          if (in_valid && out_ready) begin
            main_ld = 1'b1;
          end else if (in_valid && (SKID != 0)) begin
            // Downstream stalled: park the new beat behind the head.
            state_d = SKIDDED;
            skid_ld = 1'b1;
          end else if (!in_valid && out_ready) begin
            state_d = EMPTY;
          end
        end
        SKIDDED: begin
          if (out_ready) begin
            state_d        = FULL;
            main_from_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
      main_q     <= '0;
      skid_q     <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != SKIDDED);
      if (main_ld) begin
        main_q <= in_beat;
      end else if (main_from_skid) begin
        main_q <= skid_q;
      end
      if (skid_ld) begin
        skid_q <= in_beat;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (out_valid && !out_ready && !(&stall_q)) begin
      stall_q <= stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q.data;
  assign out_rd    = main_q.rd;
  assign out_wb    = main_q.wb;
  assign fwd_en    = out_valid & main_q.wb;
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Randomised and directed bench for pipe_stage_skid against a queue-based reference model.
module tb_pipe_stage_skid;

  localparam int DATA_W = 64;
  localparam int RD_W   = 5;
  localparam int CNT_W  = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [RD_W-1:0]   in_rd;
  logic              in_wb;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [RD_W-1:0]   out_rd;
  logic              out_wb;
  logic              fwd_en;
  logic [CNT_W-1:0]  stall_cnt;

  always #5 clk = ~clk;

  pipe_stage_skid #(
    .DATA_W(DATA_W),
    .RD_W  (RD_W),
    .SKID  (1),
    .CNT_W (CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_rd    (in_rd),
    .in_wb    (in_wb),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_rd   (out_rd),
    .out_wb   (out_wb),
    .fwd_en   (fwd_en),
    .stall_cnt(stall_cnt)
  );

  typedef struct {
    logic [DATA_W-1:0] d;
    logic [RD_W-1:0]   rd;
    logic              wb;
  } beat_t;

  // Reference: beats held by the stage (at most two), oldest first.
  beat_t mq[$];
  int    mcnt;
  int    n_vec = 0;
  int    n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    chk("out_valid", 64'(out_valid), 64'(mq.size() > 0));
    chk("in_ready",  64'(in_ready),  64'(mq.size() < 2));
    chk("stall_cnt", 64'(stall_cnt), 64'(mcnt));
    if (mq.size() > 0) begin
      chk("out_data", out_data,       mq[0].d);
      chk("out_rd",   64'(out_rd),    64'(mq[0].rd));
      chk("out_wb",   64'(out_wb),    64'(mq[0].wb));
      chk("fwd_en",   64'(fwd_en),    64'(mq[0].wb));
    end else begin
      chk("fwd_en_idle", 64'(fwd_en), 64'(0));
    end
  endtask

  // Drive one cycle (called at negedge), check, advance model, return at next negedge.
  task automatic cycle(input logic iv, input logic [DATA_W-1:0] d, input logic [RD_W-1:0] rd,
                       input logic wb, input logic ordy, input logic fl);
    beat_t b;
    bit    accept;
    in_valid  = iv;
    in_data   = d;
    in_rd     = rd;
    in_wb     = wb;
    out_ready = ordy;
    flush     = fl;
    #1;
    check_outputs();
    accept = iv && (mq.size() < 2);
    if (mq.size() > 0 && !ordy && mcnt < CNT_MAX) mcnt++;
    if (fl) begin
      mq.delete();
    end else begin
      if (mq.size() > 0 && ordy) void'(mq.pop_front());
      if (accept) begin
        b.d = d; b.rd = rd; b.wb = wb;
        mq.push_back(b);
      end
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; in_data = '0; in_rd = '0; in_wb = 1'b0;
    out_ready = 1'b0; flush = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'(0));
    chk({tag, "_in_ready"},  64'(in_ready),  64'(1));
    chk({tag, "_out_data"},  out_data,       64'(0));
    chk({tag, "_out_rd"},    64'(out_rd),    64'(0));
    chk({tag, "_out_wb"},    64'(out_wb),    64'(0));
    chk({tag, "_fwd_en"},    64'(fwd_en),    64'(0));
    chk({tag, "_stall_cnt"}, 64'(stall_cnt), 64'(0));
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    mq.delete();
    mcnt = 0;
    @(negedge clk);
    @(negedge clk);
    check_reset_values("rst");
    rst_n = 1'b1;
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    mcnt  = 0;
    do_reset();

    // Streaming with downstream always ready.
    cycle(1, 64'h1, 5'd1, 1, 1, 0);
    cycle(1, 64'h2, 5'd2, 1, 1, 0);
    cycle(1, 64'h3, 5'd3, 1, 1, 0);
    cycle(0, 64'h0, 5'd0, 0, 1, 0);
    cycle(0, 64'h0, 5'd0, 0, 1, 0);

    // Fill the skid slot, then drain in order.
    do_reset();
    cycle(1, 64'hA, 5'd4, 0, 0, 0);
    cycle(1, 64'hB, 5'd5, 0, 0, 0);
    cycle(0, 64'h0, 5'd0, 0, 0, 0);
    cycle(1, 64'hEE, 5'd6, 0, 1, 0);  // offered while not ready: must not enter
    cycle(0, 64'h0, 5'd0, 0, 1, 0);
    cycle(0, 64'h0, 5'd0, 0, 1, 0);

    // Flush while two beats are held and a third is offered.
    do_reset();
    cycle(1, 64'hA, 5'd1, 1, 0, 0);
    cycle(1, 64'hB, 5'd2, 1, 0, 0);
    cycle(1, 64'hC, 5'd3, 1, 0, 1);
    cycle(0, 64'h0, 5'd0, 0, 1, 0);
    cycle(1, 64'hD, 5'd4, 0, 1, 0);
    cycle(0, 64'h0, 5'd0, 0, 1, 0);

    // Forwarding qualifier follows the head beat.
    cycle(1, 64'h70, 5'd7, 1, 1, 0);
    cycle(1, 64'h30, 5'd3, 0, 1, 0);
    cycle(0, 64'h0,  5'd0, 0, 1, 0);
    cycle(0, 64'h0,  5'd0, 0, 1, 0);

    // Stall counter saturation.
    do_reset();
    cycle(1, 64'h55, 5'd9, 1, 0, 0);
    for (int i = 0; i < 20; i++) cycle(0, 64'h0, 5'd0, 0, 0, 0);
    chk("stall_sat", 64'(stall_cnt), 64'(CNT_MAX));
    cycle(0, 64'h0, 5'd0, 0, 1, 1);  // flush keeps the count
    cycle(0, 64'h0, 5'd0, 0, 1, 0);

    // Asynchronous reset in the middle of traffic.
    do_reset();
    cycle(1, 64'h11, 5'd1, 1, 0, 0);
    cycle(1, 64'h22, 5'd2, 1, 0, 0);
    cycle(0, 64'h0,  5'd0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1 check_reset_values("async");
    mq.delete();
    mcnt = 0;
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1, 64'h33, 5'd3, 1, 1, 0);
    cycle(0, 64'h0,  5'd0, 0, 1, 0);

    // Random traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), {$urandom, $urandom}, 5'($urandom), 1'($urandom),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));
    end
    for (int i = 0; i < 4; i++) cycle(0, 64'h0, 5'd0, 0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
